axis_current_guard: RTL

Per-axis current-tracking safety monitor. It compares the commanded motor current (DAC setpoint) against the measured current (ADC reading) on every ADC sample while the amplifier is enabled. If the error stays above threshold for a run of consecutive samples, it latches `safety_amp_disable`, which feeds the board register file's per-axis safety disable input. Four instances, one per axis, sit between the ADC/DAC interface and the board register file.

---
 rtl/axis_current_guard_if.sv | 27 ++
 rtl/axis_current_guard.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/axis_current_guard_if.sv
// ---------------------------------------------------------------------------
// axis_current_guard_if
// Purpose : sample bus from the ADC/DAC interface into one axis current guard.
// Signals : cur_cmd   - commanded current (DAC setpoint), offset binary
//           adc_in    - measured current, offset binary, same scale
//           adc_valid - single-cycle strobe qualifying adc_in
// Modports: master drives the bus, slave (the guard) receives it.
// ---------------------------------------------------------------------------
interface axis_current_guard_if;

  logic [15:0] cur_cmd;
  logic [15:0] adc_in;
  logic        adc_valid;

  modport master (
    output cur_cmd,
    output adc_in,
    output adc_valid
  );

  modport slave (
    input cur_cmd,
    input adc_in,
    input adc_valid
  );

endinterface : axis_current_guard_if

// File: rtl/axis_current_guard.sv
// ---------------------------------------------------------------------------
// axis_current_guard
// Purpose : per-axis current-tracking safety monitor. While the amplifier is
//           enabled, every ADC sample's |cur_cmd - adc_in| is compared with
//           THRESH; a run of LIMIT consecutive over-threshold samples latches
//           safety_amp_disable until clear_disable is pulsed.
// Params  : THRESH - absolute error threshold in ADC counts (strict >)
//           LIMIT  - consecutive over-threshold samples to trip, 1..255
//           BLANK  - samples ignored after enable (0 = no blanking)
// Ports   : sysclk             - system clock, rising edge
//           reset              - synchronous active-high reset
//           adc_bus            - cur_cmd / adc_in / adc_valid sample bus
//           amp_disable        - amplifier disable for this axis (1 = off)
//           clear_disable      - one-cycle pulse, clears a latched trip
//           safety_amp_disable - latched trip output (registered)
//           err_abs            - |error| of the last valid sample (registered)
//           trip_count         - trips since reset, saturating (registered)
// ---------------------------------------------------------------------------
module axis_current_guard #(
  parameter logic [15:0] THRESH = 16'h0400,
  parameter logic [7:0]  LIMIT  = 8'd100,
  parameter logic [7:0]  BLANK  = 8'd10
) (
  input  logic                 sysclk,
  input  logic                 reset,
  axis_current_guard_if.slave  adc_bus,
  input  logic                 amp_disable,
  input  logic                 clear_disable,
  output logic                 safety_amp_disable,
  output logic [16:0]          err_abs,
  output logic [7:0]           trip_count
);

  localparam int unsigned DW = 16;
  localparam int unsigned EW = DW + 1;
  localparam int unsigned CW = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BLANK   = 2'd1;
  localparam logic [1:0] ST_MONITOR = 2'd2;
  localparam logic [1:0] ST_TRIPPED = 2'd3;

  // Last blanking strobe index; only meaningful when BLANK is non-zero.
  localparam logic [CW-1:0] BLANK_LAST = BLANK - CW'(1);
  localparam logic [EW-1:0] THRESH_X   = {1'b0, THRESH};
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  // -------------------------------------------------------------------------
  // Error stage: magnitude of the 17-bit signed difference, captured with the
  // sample strobe. Offset-binary operands zero-extended so the difference
  // covers -65535..+65535 and the magnitude never overflows 17 bits.
  // -------------------------------------------------------------------------
  logic [EW-1:0] diff_c;
  logic [EW-1:0] err_mag_c;
  logic [EW-1:0] err_abs_q;
  logic          err_stb_q;

  always_comb begin
    diff_c    = {1'b0, adc_bus.cur_cmd} - {1'b0, adc_bus.adc_in};
    err_mag_c = diff_c[EW-1] ? (~diff_c + EW'(1)) : diff_c;
  end

  // Error register and its one-cycle-delayed strobe.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      err_abs_q <= '0;
      err_stb_q <= 1'b0;
    end else begin
      err_stb_q <= adc_bus.adc_valid;
      if (adc_bus.adc_valid) begin
        err_abs_q <= err_mag_c;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Supervisor FSM
  // -------------------------------------------------------------------------
  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] blank_cnt_q, blank_cnt_d;
  logic [CW-1:0] err_cnt_q,   err_cnt_d;
  logic [CW-1:0] trip_cnt_q,  trip_cnt_d;
  logic          safety_q,    safety_d;

  logic          over_c;
  logic [CW-1:0] err_cnt_inc_c;
  logic          trip_c;

  // Qualifiers shared by the MONITOR branch.
  always_comb begin
    over_c        = (err_abs_q > THRESH_X);
    err_cnt_inc_c = err_cnt_q + CW'(1);
    trip_c        = err_stb_q && over_c && (err_cnt_inc_c == LIMIT);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    err_cnt_d   = err_cnt_q;
    trip_cnt_d  = trip_cnt_q;
    safety_d    = safety_q;

    case (state_q)
      ST_IDLE: begin
        blank_cnt_d = '0;
        err_cnt_d   = '0;
        safety_d    = 1'b0;
        if (!amp_disable) begin
          state_d = (BLANK == CW'(0)) ? ST_MONITOR : ST_BLANK;
        end
      end

      ST_BLANK: begin
        if (amp_disable) begin
          state_d     = ST_IDLE;
          blank_cnt_d = '0;
          err_cnt_d   = '0;
        end else if (err_stb_q) begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_d     = ST_MONITOR;
            blank_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + CW'(1);
          end
        end
      end

      ST_MONITOR: begin
        // A qualifying trip beats a same-cycle amp_disable.
        if (trip_c) begin
          state_d   = ST_TRIPPED;
          safety_d  = 1'b1;
          err_cnt_d = err_cnt_inc_c;
          if (trip_cnt_q != CNT_MAX) begin
            trip_cnt_d = trip_cnt_q + CW'(1);
          end
        end else if (amp_disable) begin
          state_d     = ST_IDLE;
          blank_cnt_d = '0;
          err_cnt_d   = '0;
        end else if (err_stb_q) begin
          err_cnt_d = over_c ? err_cnt_inc_c : '0;
        end
      end

      ST_TRIPPED: begin
        safety_d = 1'b1;
        if (clear_disable) begin
          state_d     = ST_IDLE;
          safety_d    = 1'b0;
          blank_cnt_d = '0;
          err_cnt_d   = '0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        blank_cnt_d = '0;
        err_cnt_d   = '0;
        safety_d    = 1'b0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      blank_cnt_q <= '0;
      err_cnt_q   <= '0;
      trip_cnt_q  <= '0;
      safety_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      err_cnt_q   <= err_cnt_d;
      trip_cnt_q  <= trip_cnt_d;
      safety_q    <= safety_d;
    end
  end

  assign safety_amp_disable = safety_q;
  assign err_abs            = err_abs_q;
  assign trip_count         = trip_cnt_q;

endmodule : axis_current_guard
